// File: rtl/spm_arb_pkg.sv
// Shared definitions for the bit-serial multiply arbiter: FSM state encoding,
// operand/product widths and the requester-id width helper.
package spm_arb_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 2 * OP_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // Width of a requester id; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spm_arb_picker.sv
// Combinational one-hot grant. Searches req_valid_i circularly starting at
// ptr_i; with ptr_i held at zero this is plain lowest-index-wins priority.
module spm_arb_picker
  import spm_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_id_o
);

  // First valid requester at or after the pointer wins.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    found    = 1'b0;
    idx      = '0;
    gnt_o    = '0;
    gnt_id_o = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = ID_W'((int'(ptr_i) + off) % N_REQ);
      if (!found && valid_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
      end
    end
  end

endmodule

// File: rtl/spm_mult_arbiter.sv
// Shares one 8x8 signed bit-serial multiply engine between N_REQ requesters.
// Build option SPM_ARB_ROUND_ROBIN_EN: rotating priority (pointer moves to
// granted id + 1). Without it, lowest index wins and no pointer exists.
//
// state | meaning
// IDLE  | waiting for a request; grants and latches operands
// CLR   | engine reset pulse, clears its sticky done
// LOAD  | engine start pulse, cycle counter cleared
// RUN   | engine computing; done or timeout ends it
// RESP  | response presented until the consumer takes it
module spm_mult_arbiter
  import spm_arb_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int TIMEOUT_CYC = 24,
  localparam int ID_W        = id_w(N_REQ)
) (
  input  logic                  clk_out_i,
  input  logic                  rst_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [N_REQ*OP_W-1:0] req_x_i,
  input  logic [N_REQ*OP_W-1:0] req_y_i,
  output logic [N_REQ-1:0]      req_ready_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [PROD_W-1:0]     rsp_prod_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  eng_rst_o,
  output logic                  eng_start_o,
  output logic [OP_W-1:0]       eng_x_o,
  output logic [OP_W-1:0]       eng_y_o,
  input  logic                  eng_done_i,
  input  logic [PROD_W-1:0]     eng_prod_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OP_W-1:0]     op_x_q, op_x_d;
  logic [OP_W-1:0]     op_y_q, op_y_d;
  logic [ID_W-1:0]     op_id_q, op_id_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                err_q, err_d;
  logic [N_REQ-1:0]    gnt;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     rr_ptr;
  logic                grant_now;

  assign grant_now = (state_q == ST_IDLE) && (|req_valid_i) && !rst_i;

`ifdef SPM_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Pointer advances past the winner so every requester gets a turn.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_now) begin
      ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_out_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign rr_ptr = ptr_q;
`else
  assign rr_ptr = '0;
`endif

  spm_arb_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .valid_i  (req_valid_i),
    .ptr_i    (rr_ptr),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  // Next-state, operand/response capture and engine strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_x_d      = op_x_q;
    op_y_d      = op_y_q;
    op_id_d     = op_id_q;
    prod_d      = prod_q;
    err_d       = err_q;
    req_ready_o = '0;
    eng_start_o = 1'b0;
    eng_rst_o   = rst_i;
    case (state_q)
      ST_IDLE: begin
        if (grant_now) begin
          req_ready_o = gnt;
          op_x_d      = req_x_i[int'(gnt_id)*OP_W +: OP_W];
          op_y_d      = req_y_i[int'(gnt_id)*OP_W +: OP_W];
          op_id_d     = gnt_id;
          state_d     = ST_CLR;
        end
      end
      ST_CLR: begin
        eng_rst_o = 1'b1;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        eng_start_o = !rst_i;
        cnt_d       = '0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        // done is checked first so it beats a coincident timeout
        if (eng_done_i) begin
          prod_d  = eng_prod_i;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any response in flight.
  always_ff @(posedge clk_out_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_x_q  <= '0;
      op_y_q  <= '0;
      op_id_q <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_x_q  <= op_x_d;
      op_y_q  <= op_y_d;
      op_id_q <= op_id_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid_o = (state_q == ST_RESP);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_id_o    = op_id_q;
  assign rsp_prod_o  = prod_q;
  assign rsp_err_o   = err_q;
  assign eng_x_o     = op_x_q;
  assign eng_y_o     = op_y_q;

endmodule
